// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic {RUN, MEM_WAIT} state_e;

    localparam int REG_ADDR_W  = 5;
    localparam int WAIT_W      = 8;
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: counter that stops at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // next count: advance on inc_i unless already saturated
    always_comb begin
        cnt_d = (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // count register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline (freeze > load-use > flush)
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] if_id_rs_i,
    input  logic [REG_ADDR_W-1:0] if_id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  id_ex_memrd_i,
    input  logic [REG_ADDR_W-1:0] id_ex_rt_i,
    input  logic                  branch_taken_i,
    input  logic                  jump_i,
    input  logic                  mem_access_i,
    input  logic                  mem_ack_i,
    output logic                  pc_write_o,
    output logic                  if_id_write_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_bubble_o,
    output logic                  ex_mem_write_o,
    output logic                  mem_req_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic              freeze, load_use, redirect, timeout, advance;

    // hazard detection and next-state; a timeout releases the freeze and aborts the access
    always_comb begin
        timeout    = state_q == MEM_WAIT && !mem_ack_i && wait_cnt_q >= TMO;
        freeze     = state_q == RUN ? mem_access_i : (!mem_ack_i && wait_cnt_q < TMO);
        load_use   = id_ex_memrd_i && id_ex_rt_i != '0 &&
                     (id_ex_rt_i == if_id_rs_i || (id_uses_rt_i && id_ex_rt_i == if_id_rt_i));
        redirect   = branch_taken_i || jump_i;
        state_d    = state_q == RUN ? (mem_access_i ? MEM_WAIT : RUN)
                                    : ((mem_ack_i || timeout) ? RUN : MEM_WAIT);
        wait_cnt_d = state_q == RUN ? '0 : wait_cnt_q + 1'b1;
        err_d      = err_q || timeout;
    end

    // pipeline controls; reset forces enables off and a bubble into ID_EX
    always_comb begin
        advance        = rst_n_i && !freeze && !load_use;
        pc_write_o     = advance;
        if_id_write_o  = advance;
        if_id_flush_o  = advance && redirect;
        ex_mem_write_o = rst_n_i && !freeze;
        id_ex_bubble_o = !rst_n_i || (!freeze && load_use);
        mem_req_o      = rst_n_i && (state_q == MEM_WAIT || mem_access_i);
    end

    // FSM state, wait counter and sticky timeout flag
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err_o = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (freeze || load_use),
        .cnt_o   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (if_id_flush_o),
        .cnt_o   (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with a cycle-level reference model of the hazard rules
module tb_pipe_hazard_ctrl;

    localparam int TMO  = 4;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    rs = '0, rt = '0, ex_rt = '0;
    logic          uses_rt = 1'b0, memrd = 1'b0, br = 1'b0, jmp = 1'b0, ma = 1'b0, ack = 1'b0;
    logic          pc_write, if_id_write, if_id_flush, bubble, ex_mem_write, mem_req, err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct {
        logic [5:0] ctrl;
        logic       err;
        int         stall;
        int         flush;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0;

    bit m_busy = 0, m_err = 0;
    int m_waited = 0, m_stall = 0, m_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .if_id_rs_i     (rs),
        .if_id_rt_i     (rt),
        .id_uses_rt_i   (uses_rt),
        .id_ex_memrd_i  (memrd),
        .id_ex_rt_i     (ex_rt),
        .branch_taken_i (br),
        .jump_i         (jmp),
        .mem_access_i   (ma),
        .mem_ack_i      (ack),
        .pc_write_o     (pc_write),
        .if_id_write_o  (if_id_write),
        .if_id_flush_o  (if_id_flush),
        .id_ex_bubble_o (bubble),
        .ex_mem_write_o (ex_mem_write),
        .mem_req_o      (mem_req),
        .err_o          (err),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // drive one cycle of inputs, predict this cycle's outputs, then advance the model past the edge
    task automatic step(input logic r, input logic a, input logic k, input logic mr, input logic b,
                        input logic j, input logic u, input logic [4:0] ert, input logic [4:0] s,
                        input logic [4:0] t);
        exp_t e;
        bit   fr, lu, go;
        @(posedge clk);
        #1;
        rst_n = r; ma = a; ack = k; memrd = mr; br = b; jmp = j; uses_rt = u;
        ex_rt = ert; rs = s; rt = t;
        if (!r) begin
            m_busy = 0; m_err = 0; m_stall = 0; m_flush = 0; m_waited = 0;
            e.ctrl = 6'b000100; e.err = 0; e.stall = 0; e.flush = 0;
            q.push_back(e);
        end else begin
            fr = m_busy ? (!k && m_waited < TMO) : a;
            lu = mr && ert != 0 && (ert == s || (u && ert == t));
            go = !fr && !lu;
            e.ctrl  = {go, go, go && (b || j), !fr && lu, !fr, m_busy || a};
            e.err   = m_err;
            e.stall = m_stall;
            e.flush = m_flush;
            q.push_back(e);
            if ((fr || lu) && m_stall < MAXC) m_stall++;
            if (go && (b || j) && m_flush < MAXC) m_flush++;
            if (!m_busy) begin
                if (a) begin m_busy = 1; m_waited = 0; end
            end else if (k || m_waited >= TMO) begin
                if (!k) m_err = 1;
                m_busy = 0;
            end else m_waited++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // monitor: compare every presented cycle against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ctrl", {pc_write, if_id_write, if_id_flush, bubble, ex_mem_write, mem_req}, e.ctrl);
                chk("err", err, e.err);
                chk("stall_cnt", stall_cnt, e.stall);
                chk("flush_cnt", flush_cnt, e.flush);
            end
        end
    end

    initial begin
        step(0, 1, 0, 1, 1, 0, 1, 3, 3, 3);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset_pc_write", pc_write, 0);
        chk("reset_bubble", bubble, 1);
        idle(2);
        // single load-use bubble, then the rt=0 case that must not stall
        step(1, 0, 0, 1, 0, 0, 0, 8, 8, 2);
        idle(1);
        @(negedge clk);
        chk("stall_after_lu", stall_cnt, 1);
        step(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        idle(1);
        // jump alone flushes; jump with load-use is suppressed
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("flush_after_jump", flush_cnt, 1);
        step(1, 0, 0, 1, 0, 1, 1, 5, 1, 5);
        idle(1);
        // access acked on the third cycle after the request
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("stall_after_mem", stall_cnt, 5);
        chk("flush_after_mem", flush_cnt, 1);
        // back-to-back access then a timeout with no ack
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= TMO; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        @(negedge clk);
        chk("err_sticky", err, 1);
        // reset in the middle of a wait
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // saturate both counters
        for (int i = 0; i < MAXC + 10; i++) step(1, 0, 0, 1, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < MAXC + 10; i++) step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("stall_saturated", stall_cnt, MAXC);
        chk("flush_saturated", flush_cnt, MAXC);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(999) != 0, $urandom_range(4) == 0, $urandom_range(2) == 0,
                 $urandom_range(4) < 2, $urandom_range(6) == 0, $urandom_range(9) == 0,
                 $urandom_range(1) == 1, 5'($urandom_range(3)), 5'($urandom_range(3)),
                 5'($urandom_range(3)));
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
